// File: rtl/queue_sensor_frontend.sv
// -----------------------------------------------------------------------------
// queue_sensor_frontend
//
// Sits between the two raw queue photo-sensors and the occupancy counter.
// Each sensor line is synchronised and debounced. A filtered 0->1 level
// (beam broken) is a passage event, and it arms a pending flag. A small
// sequencer serves the pending flags one at a time. It emits a one-cycle
// up/down pulse, or a reject pulse when the counter is already full or empty.
//
// Ports
//   clock          system clock; all state changes on the rising edge
//   reset          asynchronous, active-low; clears all state
//   frontSensorRaw entry gate sensor, asynchronous, 1 = beam broken
//   backSensorRaw  exit gate sensor, asynchronous, 1 = beam broken
//   queueCount     current occupancy reported by the counter
//   upSignal       one-cycle increment pulse (registered)
//   downSignal     one-cycle decrement pulse (registered)
//   entryRejected  one-cycle pulse: entry dropped because the queue is full
//   exitRejected   one-cycle pulse: exit dropped because the queue is empty
//
// Sequencer states
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | nothing in service; arbitrate pending flags (down first)
//   PULSE | the selected output is high for this single cycle
//   GAP   | all outputs low while queueCount settles; arbitrates again
// -----------------------------------------------------------------------------
module queue_sensor_frontend #(
    parameter int numberOfBits   = 3,
    parameter int debounceCycles = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    frontSensorRaw,
    input  logic                    backSensorRaw,
    input  logic [numberOfBits-1:0] queueCount,
    output logic                    upSignal,
    output logic                    downSignal,
    output logic                    entryRejected,
    output logic                    exitRejected
);

    // Channel index 0 = front (entry), 1 = back (exit).
    localparam logic [7:0] DEB_LAST = 8'(debounceCycles - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } seq_state_t;

    logic [1:0] sync_meta;
    logic [1:0] sync_lvl;
    logic [1:0] filt_lvl;
    logic [1:0] filt_lvl_d;
    logic [7:0] deb_cnt [2];
    logic [1:0] rise;

    logic       pending_up;
    logic       pending_down;

    seq_state_t state;
    seq_state_t state_next;
    logic       serve_up;
    logic       serve_down;
    logic       up_next;
    logic       down_next;
    logic       entry_rej_next;
    logic       exit_rej_next;

    logic       is_full;
    logic       is_empty;

    // -------------------------------------------------------------------------
    // Synchroniser and debounce, both channels
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta  <= '0;
            sync_lvl   <= '0;
            filt_lvl   <= '0;
            filt_lvl_d <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync_meta  <= {backSensorRaw, frontSensorRaw};
            sync_lvl   <= sync_meta;
            filt_lvl_d <= filt_lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync_lvl[i] == filt_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    // This is the debounceCycles-th consecutive disagreeing cycle.
                    filt_lvl[i] <= ~filt_lvl[i];
                    deb_cnt[i]  <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Only the beam-broken edge counts as an event.
    assign rise = filt_lvl & ~filt_lvl_d;

    // -------------------------------------------------------------------------
    // Pending flags: set by an event, cleared when the sequencer takes them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_up   <= 1'b0;
            pending_down <= 1'b0;
        end else begin
            pending_up   <= (pending_up   & ~serve_up)   | rise[0];
            pending_down <= (pending_down & ~serve_down) | rise[1];
        end
    end

    // A channel cannot re-arm faster than the sequencer drains it.
    a_no_overrun_up : assert property (@(posedge clock) disable iff (!reset)
        !(rise[0] && pending_up));
    a_no_overrun_down : assert property (@(posedge clock) disable iff (!reset)
        !(rise[1] && pending_down));

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    assign is_full  = (queueCount == {numberOfBits{1'b1}});
    assign is_empty = (queueCount == {numberOfBits{1'b0}});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            upSignal      <= 1'b0;
            downSignal    <= 1'b0;
            entryRejected <= 1'b0;
            exitRejected  <= 1'b0;
        end else begin
            state         <= state_next;
            upSignal      <= up_next;
            downSignal    <= down_next;
            entryRejected <= entry_rej_next;
            exitRejected  <= exit_rej_next;
        end
    end

    always_comb begin
        state_next     = state;
        serve_up       = 1'b0;
        serve_down     = 1'b0;
        up_next        = 1'b0;
        down_next      = 1'b0;
        entry_rej_next = 1'b0;
        exit_rej_next  = 1'b0;

        case (state)
            // GAP runs the same arbitration as IDLE. A waiting event is then
            // served two cycles after the previous pulse. That is the gap
            // cycle plus the new pulse, and queueCount has settled by then.
            IDLE, GAP: begin
                state_next = IDLE;
                if (pending_down) begin
                    serve_down    = 1'b1;
                    state_next    = PULSE;
                    down_next     = ~is_empty;
                    exit_rej_next = is_empty;
                end else if (pending_up) begin
                    serve_up       = 1'b1;
                    state_next     = PULSE;
                    up_next        = ~is_full;
                    entry_rej_next = is_full;
                end
            end
            PULSE: begin
                state_next = GAP;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
